// File: rtl/pipe_gap_scheduler.sv
// Round-robin arbiter that hands each requester a bounded pipe gap height derived from the LFSR.
// Define PIPE_GAP_REPEAT_FILTER_EN to resample (up to 3 times) when a height repeats the last one.
module pipe_gap_scheduler #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned RND_W     = 13,
  parameter int unsigned GAP_MIN   = 64,
  parameter int unsigned GAP_RANGE = 256,
  parameter int unsigned OUT_W     = 10
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [RND_W-1:0]   rnd,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [OUT_W-1:0]   gap_y,
  output logic               gap_valid,
  output logic               busy
);

  localparam int unsigned      IW    = $clog2(NUM_REQ);
  localparam logic [RND_W-1:0] RANGE = RND_W'(GAP_RANGE);
  localparam logic [OUT_W-1:0] GMIN  = OUT_W'(GAP_MIN);

  typedef enum logic [1:0] {StIdle, StSample, StReduce, StDone} state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d, win_q, win_d, pick;
  logic             found;
  logic [RND_W-1:0] acc_q, acc_d;
  logic [OUT_W-1:0] gap_q, gap_d;
  int unsigned      sum;

`ifdef PIPE_GAP_REPEAT_FILTER_EN
  logic [RND_W-1:0] last_q, last_d;
  logic [1:0]       retry_q, retry_d;
`endif

  // Search upward from ptr+1 with wrap, so the last winner ranks last.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    sum   = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      sum = 32'(ptr_q) + i;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      if (!found && req[IW'(sum)]) begin
        found = 1'b1;
        pick  = IW'(sum);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    acc_d     = acc_q;
    gap_d     = gap_q;
    grant     = '0;
    gap_valid = 1'b0;
`ifdef PIPE_GAP_REPEAT_FILTER_EN
    last_d    = last_q;
    retry_d   = retry_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (found) begin
          win_d   = pick;
          state_d = StSample;
        end
      end
      StSample: begin
        acc_d   = rnd;
        state_d = StReduce;
      end
      StReduce: begin
        if (acc_q >= RANGE) begin
          acc_d = acc_q - RANGE;
        end else begin
`ifdef PIPE_GAP_REPEAT_FILTER_EN
          if (acc_q == last_q && retry_q != 2'd3) begin
            retry_d = retry_q + 2'd1;
            state_d = StSample;
          end else begin
            gap_d   = GMIN + OUT_W'(acc_q);
            state_d = StDone;
          end
`else
          gap_d   = GMIN + OUT_W'(acc_q);
          state_d = StDone;
`endif
        end
      end
      StDone: begin
        grant[win_q] = 1'b1;
        gap_valid    = 1'b1;
        ptr_d        = win_q;
        state_d      = StIdle;
`ifdef PIPE_GAP_REPEAT_FILTER_EN
        last_d       = acc_q;
        retry_d      = 2'd0;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy  = (state_q != StIdle);
  assign gap_y = gap_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      ptr_q   <= IW'(NUM_REQ - 1);
      win_q   <= '0;
      acc_q   <= '0;
      gap_q   <= '0;
`ifdef PIPE_GAP_REPEAT_FILTER_EN
      last_q  <= '1;
      retry_q <= 2'd0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      acc_q   <= acc_d;
      gap_q   <= gap_d;
`ifdef PIPE_GAP_REPEAT_FILTER_EN
      last_q  <= last_d;
      retry_q <= retry_d;
`endif
    end
  end

endmodule
